// File: rtl/lock_access_ctrl.sv
// Keypad access controller: collects PIN digits, checks them against the stored password,
// sequences the door-lock timer and services password programming. Optional macro: LOCK_DIGIT_TIMEOUT_EN.
module lock_access_ctrl #(
    parameter int unsigned PW_LEN        = 4,
    parameter logic [31:0] DEFAULT_PW    = 32'h0000_1234,
    parameter int unsigned DIGIT_TIMEOUT = 5
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [2:0] timer_state,
    output logic       enb_lock,
    output logic       gen_stop,
    output logic [2:0] error_counter,
    output logic       pw_update_done,
    output logic [2:0] ctrl_state
);

    localparam int unsigned PW_W  = PW_LEN * 4;
    localparam int unsigned CNT_W = $clog2(PW_LEN + 1);

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [2:0] TS_IDLE    = 3'd0;
    localparam logic [2:0] TS_NEW     = 3'd4;
    localparam logic [2:0] TS_WRONG   = 3'd6;
    localparam logic [2:0] TS_WARNING = 3'd7;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        CHECK   = 3'd1,
        GRANT   = 3'd2,
        PROG    = 3'd3,
        DENY    = 3'd4,
        RELEASE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [PW_W-1:0]   buf_q, buf_d;
    logic [PW_W-1:0]   pw_q, pw_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              seen_q, seen_d;
    logic [2:0]        err_d;
    logic              done_d;
    logic              key_acc;
    logic              full;

`ifdef LOCK_DIGIT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(DIGIT_TIMEOUT + 1);
    logic [TMO_W-1:0]  tmo_q, tmo_d;
`else
    logic unused_ok;
    assign unused_ok = ^{tick_1hz, DIGIT_TIMEOUT[0]};
`endif

    assign key_acc = key_valid && key_ready;
    assign full    = (cnt_q == CNT_W'(PW_LEN));

    // Next-state, datapath and error-count update
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pw_d    = pw_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        seen_d  = seen_q;
        err_d   = error_counter;
        done_d  = 1'b0;
`ifdef LOCK_DIGIT_TIMEOUT_EN
        tmo_d   = '0;
`endif
        case (state_q)
            COLLECT, PROG: begin
                if (state_q == PROG && timer_state == TS_IDLE) begin
                    state_d = COLLECT;
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
`ifdef LOCK_DIGIT_TIMEOUT_EN
                    // Idle ticks only count with a partial entry; an accepted key restarts the count
                    tmo_d = tmo_q;
                    if (key_acc || cnt_q == '0) begin
                        tmo_d = '0;
                    end else if (tick_1hz) begin
                        if (tmo_q == TMO_W'(DIGIT_TIMEOUT - 1)) begin
                            tmo_d = '0;
                            buf_d = '0;
                            cnt_d = '0;
                            ovf_d = 1'b0;
                        end else begin
                            tmo_d = tmo_q + TMO_W'(1);
                        end
                    end
`endif
                    if (key_acc) begin
                        if (key_code <= 4'd9) begin
                            if (full) begin
                                ovf_d = 1'b1;
                            end else begin
                                for (int unsigned i = 0; i < PW_LEN; i++) begin
                                    if (cnt_q == CNT_W'(i)) buf_d[(PW_LEN-1-i)*4 +: 4] = key_code;
                                end
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            buf_d = '0;
                            cnt_d = '0;
                            ovf_d = 1'b0;
                        end else if (key_code == KEY_ENTER) begin
                            if (state_q == COLLECT) begin
                                state_d = CHECK;
                            end else begin
                                if (full && !ovf_q) begin
                                    pw_d    = buf_q;
                                    done_d  = 1'b1;
                                    state_d = GRANT;
                                end
                                buf_d = '0;
                                cnt_d = '0;
                                ovf_d = 1'b0;
                            end
                        end
                    end
                end
            end
            CHECK: begin
                if (full && !ovf_q && buf_q == pw_q) begin
                    err_d   = 3'd0;
                    state_d = GRANT;
                end else begin
                    if (error_counter != 3'd7) err_d = error_counter + 3'd1;
                    state_d = DENY;
                end
                buf_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end
            GRANT: begin
                if (timer_state != TS_IDLE) seen_d = 1'b1;
                if (timer_state == TS_NEW) begin
                    state_d = PROG;
                end else if (seen_q && timer_state == TS_IDLE) begin
                    state_d = COLLECT;
                end
            end
            DENY: begin
                if (timer_state == TS_WRONG || timer_state == TS_WARNING) state_d = RELEASE;
            end
            RELEASE: begin
                if (timer_state == TS_IDLE) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
        if (state_d != GRANT && state_d != PROG) seen_d = 1'b0;
    end

    // State and registered outputs, decoded from the next state
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q        <= COLLECT;
            buf_q          <= '0;
            pw_q           <= DEFAULT_PW[PW_W-1:0];
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            seen_q         <= 1'b0;
            key_ready      <= 1'b1;
            enb_lock       <= 1'b0;
            gen_stop       <= 1'b0;
            error_counter  <= 3'd0;
            pw_update_done <= 1'b0;
            ctrl_state     <= 3'd0;
`ifdef LOCK_DIGIT_TIMEOUT_EN
            tmo_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            pw_q           <= pw_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            seen_q         <= seen_d;
            key_ready      <= (state_d == COLLECT) || (state_d == PROG);
            enb_lock       <= (state_d == GRANT) || (state_d == PROG);
            gen_stop       <= (state_d == DENY);
            error_counter  <= err_d;
            pw_update_done <= done_d;
            ctrl_state     <= state_d;
`ifdef LOCK_DIGIT_TIMEOUT_EN
            tmo_q          <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Directed self-checking bench for lock_access_ctrl: grant, deny, error counting,
// password programming, overflow, inter-digit timeout and reset.
module tb_lock_access_ctrl;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [2:0] timer_state;
    logic       enb_lock;
    logic       gen_stop;
    logic [2:0] error_counter;
    logic       pw_update_done;
    logic [2:0] ctrl_state;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    lock_access_ctrl dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .tick_1hz       (tick_1hz),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_ready      (key_ready),
        .timer_state    (timer_state),
        .enb_lock       (enb_lock),
        .gen_stop       (gen_stop),
        .error_counter  (error_counter),
        .pw_update_done (pw_update_done),
        .ctrl_state     (ctrl_state)
    );

    always #4 clk_in = ~clk_in;

    task automatic press(input logic [3:0] c);
        @(negedge clk_in);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk_in);
        key_valid = 1'b0;
    endtask

    // Walks the timer back to IDLE from either GRANT or DENY
    task automatic finish_attempt();
        @(negedge clk_in);
        timer_state = 3'd6;
        @(negedge clk_in);
        timer_state = 3'd0;
        @(negedge clk_in);
    endtask

    task automatic try_pw(input logic [31:0] d, input int n, output logic granted, output logic [2:0] err);
        logic [3:0] k;
        for (int i = 0; i < n; i++) begin
            k = d[(n-1-i)*4 +: 4];
            press(k);
        end
        press(4'hA);
        @(negedge clk_in);
        granted = enb_lock;
        err     = error_counter;
        finish_attempt();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick_1hz = 1'b0;
        key_valid = 1'b0;
        key_code = 4'h0;
        timer_state = 3'd0;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        chk_cnt++; if (key_ready !== 1'b1) $display("FAIL rst_key_ready: got %b want 1", key_ready); else pass_cnt++;
        chk_cnt++; if (enb_lock !== 1'b0) $display("FAIL rst_enb_lock: got %b want 0", enb_lock); else pass_cnt++;
        chk_cnt++; if (gen_stop !== 1'b0) $display("FAIL rst_gen_stop: got %b want 0", gen_stop); else pass_cnt++;
        chk_cnt++; if (error_counter !== 3'd0) $display("FAIL rst_err: got %0d want 0", error_counter); else pass_cnt++;
        chk_cnt++; if (pw_update_done !== 1'b0) $display("FAIL rst_done: got %b want 0", pw_update_done); else pass_cnt++;
        chk_cnt++; if (ctrl_state !== 3'd0) $display("FAIL rst_state: got %0d want 0", ctrl_state); else pass_cnt++;
    endtask

    task automatic test_grant();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
        chk_cnt++; if (ctrl_state !== 3'd1) $display("FAIL grant_check_state: got %0d want 1", ctrl_state); else pass_cnt++;
        chk_cnt++; if (enb_lock !== 1'b0) $display("FAIL grant_early_enb: got %b want 0", enb_lock); else pass_cnt++;
        @(negedge clk_in);
        chk_cnt++; if (enb_lock !== 1'b1) $display("FAIL grant_enb: got %b want 1", enb_lock); else pass_cnt++;
        chk_cnt++; if (error_counter !== 3'd0) $display("FAIL grant_err: got %0d want 0", error_counter); else pass_cnt++;
        chk_cnt++; if (ctrl_state !== 3'd2) $display("FAIL grant_state: got %0d want 2", ctrl_state); else pass_cnt++;
        timer_state = 3'd1;
        @(negedge clk_in); timer_state = 3'd2;
        @(negedge clk_in);
        chk_cnt++; if (enb_lock !== 1'b1) $display("FAIL grant_hold: got %b want 1", enb_lock); else pass_cnt++;
        timer_state = 3'd0;
        @(negedge clk_in);
        chk_cnt++; if (enb_lock !== 1'b0) $display("FAIL grant_release_enb: got %b want 0", enb_lock); else pass_cnt++;
        chk_cnt++; if (ctrl_state !== 3'd0) $display("FAIL grant_release_state: got %0d want 0", ctrl_state); else pass_cnt++;
    endtask

    task automatic test_deny();
        press(4'h1); press(4'h2); press(4'h3); press(4'h5); press(4'hA);
        @(negedge clk_in);
        chk_cnt++; if (gen_stop !== 1'b1) $display("FAIL deny_stop: got %b want 1", gen_stop); else pass_cnt++;
        chk_cnt++; if (error_counter !== 3'd1) $display("FAIL deny_err: got %0d want 1", error_counter); else pass_cnt++;
        chk_cnt++; if (enb_lock !== 1'b0) $display("FAIL deny_enb: got %b want 0", enb_lock); else pass_cnt++;
        chk_cnt++; if (key_ready !== 1'b0) $display("FAIL deny_ready: got %b want 0", key_ready); else pass_cnt++;
        timer_state = 3'd7;
        @(negedge clk_in);
        chk_cnt++; if (gen_stop !== 1'b0) $display("FAIL release_stop: got %b want 0", gen_stop); else pass_cnt++;
        chk_cnt++; if (key_ready !== 1'b0) $display("FAIL release_ready: got %b want 0", key_ready); else pass_cnt++;
        chk_cnt++; if (ctrl_state !== 3'd5) $display("FAIL release_state: got %0d want 5", ctrl_state); else pass_cnt++;
        timer_state = 3'd0;
        @(negedge clk_in);
        chk_cnt++; if (key_ready !== 1'b1) $display("FAIL release_done_ready: got %b want 1", key_ready); else pass_cnt++;
        chk_cnt++; if (error_counter !== 3'd1) $display("FAIL release_err_persist: got %0d want 1", error_counter); else pass_cnt++;
    endtask

    task automatic test_error_count();
        logic g;
        logic [2:0] e;
        logic [2:0] exp_e;
        for (int i = 0; i < 3; i++) begin
            try_pw(32'h1111, 4, g, e);
            exp_e = 3'(i + 2);
            chk_cnt++; if (e !== exp_e) $display("FAIL err_step%0d: got %0d want %0d", i, e, exp_e); else pass_cnt++;
        end
        try_pw(32'h1234, 4, g, e);
        chk_cnt++; if (g !== 1'b1) $display("FAIL err_grant: got %b want 1", g); else pass_cnt++;
        chk_cnt++; if (e !== 3'd0) $display("FAIL err_clear: got %0d want 0", e); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            try_pw(32'h4321, 4, g, e);
            exp_e = (i >= 6) ? 3'd7 : 3'(i + 1);
            chk_cnt++; if (e !== exp_e) $display("FAIL err_sat%0d: got %0d want %0d", i, e, exp_e); else pass_cnt++;
        end
        try_pw(32'h1234, 4, g, e);
        chk_cnt++; if (e !== 3'd0) $display("FAIL err_sat_clear: got %0d want 0", e); else pass_cnt++;
    endtask

    task automatic test_prog();
        logic g;
        logic [2:0] e;
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
        @(negedge clk_in);
        chk_cnt++; if (enb_lock !== 1'b1) $display("FAIL prog_grant: got %b want 1", enb_lock); else pass_cnt++;
        timer_state = 3'd4;
        @(negedge clk_in);
        chk_cnt++; if (ctrl_state !== 3'd3) $display("FAIL prog_state: got %0d want 3", ctrl_state); else pass_cnt++;
        chk_cnt++; if (key_ready !== 1'b1) $display("FAIL prog_ready: got %b want 1", key_ready); else pass_cnt++;
        press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hA);
        chk_cnt++; if (pw_update_done !== 1'b1) $display("FAIL prog_done: got %b want 1", pw_update_done); else pass_cnt++;
        chk_cnt++; if (enb_lock !== 1'b1) $display("FAIL prog_enb: got %b want 1", enb_lock); else pass_cnt++;
        @(negedge clk_in);
        chk_cnt++; if (pw_update_done !== 1'b0) $display("FAIL prog_done_pulse: got %b want 0", pw_update_done); else pass_cnt++;
        timer_state = 3'd0;
        @(negedge clk_in);
        chk_cnt++; if (ctrl_state !== 3'd0) $display("FAIL prog_exit_state: got %0d want 0", ctrl_state); else pass_cnt++;
        chk_cnt++; if (enb_lock !== 1'b0) $display("FAIL prog_exit_enb: got %b want 0", enb_lock); else pass_cnt++;
        try_pw(32'h1234, 4, g, e);
        chk_cnt++; if (g !== 1'b0) $display("FAIL prog_old_pw: got %b want 0", g); else pass_cnt++;
        try_pw(32'h9876, 4, g, e);
        chk_cnt++; if (g !== 1'b1) $display("FAIL prog_new_pw: got %b want 1", g); else pass_cnt++;
    endtask

    task automatic test_overflow_timeout();
        logic g;
        logic [2:0] e;
        logic exp_g;
        try_pw(32'h98765, 5, g, e);
        chk_cnt++; if (g !== 1'b0) $display("FAIL ovf_grant: got %b want 0", g); else pass_cnt++;
        try_pw(32'h0, 0, g, e);
        chk_cnt++; if (g !== 1'b0) $display("FAIL empty_enter: got %b want 0", g); else pass_cnt++;
        press(4'h9); press(4'h8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in); tick_1hz = 1'b1;
            @(negedge clk_in); tick_1hz = 1'b0;
        end
        press(4'h7); press(4'h6); press(4'hA);
        @(negedge clk_in);
`ifdef LOCK_DIGIT_TIMEOUT_EN
        exp_g = 1'b0;
`else
        exp_g = 1'b1;
`endif
        chk_cnt++; if (enb_lock !== exp_g) $display("FAIL timeout_entry: got %b want %b", enb_lock, exp_g); else pass_cnt++;
        finish_attempt();
    endtask

    task automatic test_reset_prog();
        logic g;
        logic [2:0] e;
        press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hA);
        @(negedge clk_in);
        timer_state = 3'd4;
        @(negedge clk_in);
        press(4'h5); press(4'h5); press(4'h5); press(4'h5); press(4'hA);
        chk_cnt++; if (pw_update_done !== 1'b1) $display("FAIL rprog_done: got %b want 1", pw_update_done); else pass_cnt++;
        press(4'h1);
        @(negedge clk_in);
        reset = 1'b1;
        timer_state = 3'd0;
        @(negedge clk_in);
        reset = 1'b0;
        chk_cnt++; if (enb_lock !== 1'b0) $display("FAIL rprog_enb: got %b want 0", enb_lock); else pass_cnt++;
        chk_cnt++; if (error_counter !== 3'd0) $display("FAIL rprog_err: got %0d want 0", error_counter); else pass_cnt++;
        chk_cnt++; if (ctrl_state !== 3'd0) $display("FAIL rprog_state: got %0d want 0", ctrl_state); else pass_cnt++;
        try_pw(32'h1234, 4, g, e);
        chk_cnt++; if (g !== 1'b1) $display("FAIL rprog_default_pw: got %b want 1", g); else pass_cnt++;
        try_pw(32'h5555, 4, g, e);
        chk_cnt++; if (g !== 1'b0) $display("FAIL rprog_stale_pw: got %b want 0", g); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_grant();
        test_deny();
        test_error_count();
        test_prog();
        test_overflow_timeout();
        test_reset_prog();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/lock_access_ctrl.md
# lock_access_ctrl

Keypad-side access controller that sequences the door-lock timer block. It collects PIN digits, compares them with the stored password, and drives the timer's `enb_lock`, `gen_stop` and `error_counter` inputs. It also services new-password programming while the timer sits in its NEW state. It sits between the debounced keypad decoder and the timer block, and is the sole owner of the error count.

## Interface
- `PW_LEN`, 4: password length in digits (1–8).
- `DEFAULT_PW`, 32'h0000_1234: reset password, 4 bits per digit, right-aligned; digit 0 is the most significant used nibble.
- `DIGIT_TIMEOUT`, 5: inter-digit timeout, in `tick_1hz` pulses.
- `clk_in`  in  1  system clock, 128 MHz.
- `reset`  in  1  synchronous, active-high.
- `tick_1hz`  in  1  one-cycle pulse at 1 Hz.
- `key_valid`  in  1  key event valid.
- `key_code`  in  4  0–9 digit, 4'hA ENTER, 4'hB CLEAR; 4'hC–4'hF ignored.
- `key_ready`  out  1  controller accepts a key this cycle.
- `timer_state`  in  3  timer state: 0 IDLE, 1 WAIT, 2 OPEN, 3 CLOSE, 4 NEW, 5 EXIT, 6 WRONG, 7 WARNING.
- `enb_lock`  out  1  to timer; access granted.
- `gen_stop`  out  1  to timer; wrong attempt.
- `error_counter`  out  3  to timer; consecutive wrong attempts, saturating at 7.
- `pw_update_done`  out  1  one-cycle pulse when a new password is committed.
- `ctrl_state`  out  3  current FSM state, for debug.

## Operation
- FSM states:
  - COLLECT=0, CHECK=1, GRANT=2, PROG=3, DENY=4, RELEASE=5.
  - Reset puts the FSM in COLLECT.
- Key handshake:
  - A key is accepted when `key_valid && key_ready`.
  - `key_ready`=1 only in COLLECT and PROG.
- COLLECT:
  - Each digit is stored at position `cnt`, then `cnt` increments.
  - A digit arriving with `cnt==PW_LEN` sets `ovf` instead of being stored; `cnt` holds.
  - CLEAR zeroes `cnt` and `ovf`.
  - ENTER moves to CHECK.
- CHECK (1 cycle):
  - Match means `cnt==PW_LEN && !ovf && buffer==password`.
  - On match: `error_counter` clears to 0 and the FSM goes to GRANT.
  - On mismatch: `error_counter` increments, saturating at 7, and the FSM goes to DENY.
  - In both cases the buffer, `cnt` and `ovf` clear.
- GRANT:
  - `enb_lock`=1.
  - Set `seen_active` once `timer_state!=0`.
  - `timer_state==4` → PROG.
  - `seen_active && timer_state==0` → COLLECT, and `enb_lock` drops.
- PROG:
  - `enb_lock` stays 1.
  - Digits collect exactly as in COLLECT.
  - ENTER with `cnt==PW_LEN && !ovf` commits the buffer to the password register, pulses `pw_update_done`, and returns to GRANT.
  - ENTER otherwise only clears the buffer.
  - `timer_state==0` aborts to COLLECT with the password unchanged.
- DENY:
  - `gen_stop`=1, held until `timer_state` is 6 or 7, then → RELEASE.
  - `error_counter` is already stable when `gen_stop` rises.
- RELEASE:
  - Keys are blocked.
  - Wait for `timer_state==0`, then → COLLECT.
  - The error count persists until a successful match or `reset`.
- Boundary cases:
  - ENTER with `cnt==0` is a wrong attempt.
  - `key_valid` in a non-accepting state is dropped; no queueing.
  - `reset` in any state applies all reset values next edge. This includes `password`=`DEFAULT_PW` and `error_counter`=0.

## Timing
- Reset values:
  - `key_ready`=1, `enb_lock`=0, `gen_stop`=0, `error_counter`=0.
  - `pw_update_done`=0, `ctrl_state`=0.
  - `cnt`=0, `ovf`=0, `seen_active`=0.
- All outputs are registered.
- ENTER accepted at edge N → CHECK during N+1.
- Result visible at N+2:
  - `enb_lock`=1 on a match.
  - `gen_stop`=1 and the updated `error_counter` on a mismatch.
- `pw_update_done` is high for exactly the cycle after the committing ENTER edge.
- Timeout counter:
  - Counts `tick_1hz` while in COLLECT/PROG with `cnt>0`.
  - Resets on every accepted key.
  - On reaching `DIGIT_TIMEOUT`: buffer, `cnt` and `ovf` clear in the same cycle; the state is unchanged.
- If `tick_1hz` and a key are accepted in the same cycle, the key wins and the counter resets.

## Configuration
- `LOCK_DIGIT_TIMEOUT_EN` defined: the inter-digit timeout is active as described under Timing.
- Undefined: the timeout logic is removed, `tick_1hz` is unused, and a partial entry persists until CLEAR, ENTER or `reset`.

## Test plan
- Reset, key 1,2,3,4,ENTER → `enb_lock`=1 two cycles after the ENTER edge, `error_counter`=0. Drive `timer_state` 1→2→0 → `enb_lock`=0 and the FSM is in COLLECT.
- Key 1,2,3,5,ENTER → `gen_stop`=1 with `error_counter`=1. Drive `timer_state`=7 → `gen_stop`=0 and `key_ready`=0. Drive `timer_state`=0 → `key_ready`=1.
- Three wrong entries, then 1,2,3,4 → `error_counter` 1,2,3, then 0 on the grant. Eight wrong entries → `error_counter` saturates at 7.
- Grant, `timer_state`=4, key 9,8,7,6,ENTER → one-cycle `pw_update_done`. After release, 1,2,3,4 is denied and 9,8,7,6 is granted.
- Key 1,2,3,4,5,ENTER → denied (`ovf`). Key 1,2, then 5 ticks idle, then 3,4,ENTER → denied. With the macro undefined, the same sequence is granted.
- `reset` asserted mid-PROG after a changed password → `enb_lock`=0, `error_counter`=0, and 1,2,3,4 is granted.
